mem_resp_sram: RTL and testbench
================================

MEM_RESP_SRAM -- requirements
Module: mem_resp_sram

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the storage depth in `RW-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from a request strobe to its termination pulse; legal range 1..15.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the `WB_ADDR_W-bit word address of storage word 0.
REQ-004 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 mem_req  input  1  one-cycle start strobe for a transfer.
REQ-007 mem_we  input  1  1 = write, 0 = read; valid with mem_req and held until termination.
REQ-008 mem_addr  input  `WB_ADDR_W  word address; valid with mem_req and held until termination.
REQ-009 mem_o_data  input  `RW  write data from the initiator; valid with mem_req and held until termination.
REQ-010 mem_sel  input  2  byte-lane enables; bit 0 = bits 7:0, bit 1 = bits 15:8.
REQ-011 mem_cache_enable  input  1  cacheability hint; accepted and ignored.
REQ-012 mem_ack  output  1  one-cycle successful-termination pulse.
REQ-013 mem_i_data  output  `RW  read data to the initiator.
REQ-014 mem_exception  output  1  one-cycle error-termination pulse.

Function
REQ-015 The block SHALL be a responder on the same memory request protocol that the data-cache arbiter drives downstream, so that it connects directly to the arbiter's mem_* port.
REQ-016 The state machine SHALL have states IDLE and WAIT.
REQ-017 In IDLE, mem_req = 1 SHALL move to WAIT and load the latency counter with LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement by 1 per cycle while it is nonzero.
REQ-019 In WAIT with counter = 0, the block SHALL register exactly one termination pulse and return to IDLE, so the pulse occurs exactly LATENCY cycles after the cycle of mem_req.
REQ-020 A request SHALL be in range when BASE_ADDR <= mem_addr < BASE_ADDR + 2^DEPTH_LOG2, using unsigned `WB_ADDR_W-bit comparison with no wrap-around.
REQ-021 Termination SHALL be mem_ack = 1 for in-range requests and mem_exception = 1 for out-of-range requests; both SHALL never be high together.
REQ-022 For an in-range write, in the termination cycle, storage[mem_addr - BASE_ADDR] bits 7:0 SHALL update from mem_o_data when mem_sel[0] = 1, and bits 15:8 SHALL update when mem_sel[1] = 1.
REQ-023 A write with mem_sel = 00 SHALL still be acknowledged and SHALL leave storage unchanged.
REQ-024 An out-of-range write SHALL NOT modify storage.
REQ-025 For an in-range read, mem_i_data SHALL carry the full stored word during the mem_ack cycle, regardless of mem_sel.
REQ-026 mem_i_data SHALL be 0 in every cycle that is not an in-range read mem_ack cycle, including exception cycles.
REQ-027 Request fields SHALL be sampled in the termination cycle; the initiator holds them stable until then.
REQ-028 mem_req asserted while in WAIT (protocol violation) SHALL be ignored, and the transfer in progress SHALL complete unchanged.
REQ-029 mem_req in the cycle after a termination pulse SHALL be accepted normally, with no turnaround bubble.
REQ-030 mem_ack, mem_exception and mem_i_data SHALL be driven from registers, with no combinational path from any input.

Reset
REQ-031 While i_rst_n = 0, the block SHALL immediately force state to IDLE, counter to 0, mem_ack to 0, mem_exception to 0 and mem_i_data to 0, independent of i_clk.
REQ-032 Reset asserted during WAIT SHALL abort the transfer with no termination pulse and no storage write.
REQ-033 Storage contents SHALL NOT be reset and are undefined until written.
REQ-034 After i_rst_n deasserts, the first rising edge SHALL be able to accept mem_req.

Verification
REQ-035 Defaults, write addr 0x000005 data 0x1234 sel 11, req at cycle 0 -> mem_ack high in cycle 2 only; a subsequent read of 0x000005 -> mem_ack with mem_i_data 0x1234.
REQ-036 Write addr 5 data 0xABCD sel 01, then read addr 5 -> 0x12CD; a following sel 00 write of 0xFFFF, then read -> still 0x12CD.
REQ-037 Write addr 0x000100 data 0x5555 -> mem_exception in cycle 2, mem_ack 0, mem_i_data 0; read of addr 0x000000 -> prior contents unchanged.
REQ-038 Extra mem_req pulse at cycle 1 of a transfer -> single mem_ack at cycle 2; new req at cycle 3 -> mem_ack at cycle 5.
REQ-039 i_rst_n low mid-cycle during WAIT of a write to addr 7 -> outputs 0 without waiting for a clock edge, no pulse; a later read of addr 7 -> old value.
REQ-040 LATENCY=1, read req at cycle 0 -> mem_ack in cycle 1; back-to-back reqs at cycles 2 and 4 -> acks at cycles 3 and 5.

Source files
------------

// File: rtl/mem_resp_sram.sv
// Fixed-latency SRAM responder on the data-cache arbiter's downstream mem_* request port.
// Latency: termination pulse (mem_ack or mem_exception) exactly LATENCY cycles after mem_req.
// Backpressure: none; one transfer at a time, mem_req while busy is ignored, no turnaround bubble.

`ifndef RW
`define RW 16
`endif
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module mem_resp_sram #(
    parameter int                     DEPTH_LOG2 = 8,
    parameter int                     LATENCY    = 2,
    parameter logic [`WB_ADDR_W-1:0]  BASE_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [`WB_ADDR_W-1:0] mem_addr,
    input  logic [`RW-1:0]        mem_o_data,
    input  logic [1:0]            mem_sel,
    input  logic                  mem_cache_enable,
    output logic                  mem_ack,
    output logic [`RW-1:0]        mem_i_data,
    output logic                  mem_exception
);

    localparam int AW    = `WB_ADDR_W;
    localparam int DW    = `RW;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Counter is loaded with LATENCY-1; LATENCY is at most 15, so 4 bits suffice.
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    // One bit wider than the address so BASE_ADDR + DEPTH cannot wrap.
    localparam logic [AW:0] LIMIT  = {1'b0, BASE_ADDR} + ((AW+1)'(1) << DEPTH_LOG2);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       fire;

    logic [DW-1:0]         storage [DEPTH];
    logic [AW-1:0]         offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  wr_en;

    // Cacheability hint is accepted but has no effect on this responder.
    logic unused_bits;
    assign unused_bits = ^{mem_cache_enable, offset};

    assign offset   = mem_addr - BASE_ADDR;
    assign idx      = offset[DEPTH_LOG2-1:0];
    assign in_range = (mem_addr >= BASE_ADDR) && ({1'b0, mem_addr} < LIMIT);

    // State and latency counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a request in IDLE starts the count; WAIT counts down and
    // returns to IDLE after its final (termination) cycle. Requests in WAIT are ignored.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The cycle spent in WAIT with a zero counter is the termination cycle; its
    // registered outputs are loaded on the edge that enters it.
    always_comb begin
        fire  = (state_nxt == WAIT) && (cnt_nxt == 4'd0);
        wr_en = fire && mem_we && in_range;
    end

    // Byte-lane write into storage; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            if (mem_sel[0]) storage[idx][7:0]  <= mem_o_data[7:0];
            if (mem_sel[1]) storage[idx][15:8] <= mem_o_data[15:8];
        end
    end

    // Registered termination pulses and read data, zero outside in-range read acks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_ack       <= 1'b0;
            mem_exception <= 1'b0;
            mem_i_data    <= '0;
        end else begin
            mem_ack       <= fire && in_range;
            mem_exception <= fire && !in_range;
            mem_i_data    <= (fire && in_range && !mem_we) ? storage[idx] : '0;
        end
    end

endmodule

// File: tb/tb_mem_resp_sram.sv
// Bench for mem_resp_sram: default instance (LATENCY=2) and a LATENCY=1 instance.
// Latency: each transfer is checked cycle by cycle from its request to its termination.
// Backpressure: none; transfers are issued back to back with no idle cycle.

module tb_mem_resp_sram;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_o_data;
    logic [1:0]  mem_sel;
    logic        mem_cache_enable;

    // tgt selects which instance receives requests: 0 = LATENCY 2, 1 = LATENCY 1.
    bit          tgt;
    logic        req0, req1;
    logic        ack0, ack1, exc0, exc1;
    logic [15:0] rd0, rd1;
    logic        ack_s, exc_s;
    logic [15:0] rd_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage per instance; a word is known only once both bytes were written.
    logic [15:0] ref_mem [2][256];
    bit          ref_vld [2][256];

    always #5 i_clk = ~i_clk;

    assign req0  = mem_req & ~tgt;
    assign req1  = mem_req & tgt;
    assign ack_s = tgt ? ack1 : ack0;
    assign exc_s = tgt ? exc1 : exc0;
    assign rd_s  = tgt ? rd1  : rd0;

    mem_resp_sram dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .mem_req          (req0),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_o_data       (mem_o_data),
        .mem_sel          (mem_sel),
        .mem_cache_enable (mem_cache_enable),
        .mem_ack          (ack0),
        .mem_i_data       (rd0),
        .mem_exception    (exc0)
    );

    mem_resp_sram #(.LATENCY(1)) dut1 (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .mem_req          (req1),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_o_data       (mem_o_data),
        .mem_sel          (mem_sel),
        .mem_cache_enable (mem_cache_enable),
        .mem_ack          (ack1),
        .mem_i_data       (rd1),
        .mem_exception    (exc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t tgt=%0d)", tag, got, exp, $time, tgt);
        end
    endtask

    // Issue one transfer starting just after a rising edge; checks cycles 0..lat.
    // 'extra' adds an illegal second req pulse in cycle 1. Returns just after the
    // edge that opens the cycle following termination.
    task automatic xfer(input bit we, input logic [23:0] a, input logic [15:0] d,
                        input logic [1:0] s, input bit extra);
        int          lat;
        bit          inr;
        bit          rd_known;
        logic [15:0] exp_rd;
        lat      = tgt ? 1 : 2;
        inr      = (a < 24'h000100);
        rd_known = 1'b1;
        exp_rd   = 16'h0000;
        if (inr && !we) begin
            rd_known = ref_vld[tgt][a[7:0]];
            exp_rd   = ref_mem[tgt][a[7:0]];
        end
        mem_req          = 1'b1;
        mem_we           = we;
        mem_addr         = a;
        mem_o_data       = d;
        mem_sel          = s;
        mem_cache_enable = 1'($urandom);
        @(negedge i_clk);
        chk("ack_c0", ack_s, 0);
        chk("exc_c0", exc_s, 0);
        chk("rd_c0",  rd_s,  0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge i_clk);
            #1;
            mem_req = (c == 1) ? extra : 1'b0;
            @(negedge i_clk);
            chk("ack", ack_s, (c == lat) && inr);
            chk("exc", exc_s, (c == lat) && !inr);
            if (c != lat || rd_known)
                chk("rdata", rd_s, (c == lat) ? exp_rd : 16'h0000);
        end
        if (inr && we) begin
            if (s[0]) ref_mem[tgt][a[7:0]][7:0]  = d[7:0];
            if (s[1]) ref_mem[tgt][a[7:0]][15:8] = d[15:8];
            if (s == 2'b11) ref_vld[tgt][a[7:0]] = 1'b1;
        end
        @(posedge i_clk);
        #1;
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ra;
        for (int i = 0; i < 256; i++) begin
            ref_vld[0][i] = 1'b0;
            ref_vld[1][i] = 1'b0;
            ref_mem[0][i] = 16'h0000;
            ref_mem[1][i] = 16'h0000;
        end
        tgt              = 1'b0;
        i_rst_n          = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_o_data       = '0;
        mem_sel          = '0;
        mem_cache_enable = 1'b0;
        #2;
        chk("rst_ack0", ack0, 0);
        chk("rst_exc0", exc0, 0);
        chk("rst_rd0",  rd0,  0);
        chk("rst_ack1", ack1, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Full write then read back.
        xfer(1'b1, 24'h000005, 16'h1234, 2'b11, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b00, 1'b0);
        // Lane-masked write, then an all-lanes-off write.
        xfer(1'b1, 24'h000005, 16'hABCD, 2'b01, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b10, 1'b0);
        chk("lane_model", ref_mem[0][5], 16'h12CD);
        xfer(1'b1, 24'h000005, 16'hFFFF, 2'b00, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b11, 1'b0);
        // Out-of-range write must raise an exception and leave storage alone.
        xfer(1'b1, 24'h000000, 16'h4321, 2'b11, 1'b0);
        xfer(1'b1, 24'h000100, 16'h5555, 2'b11, 1'b0);
        xfer(1'b0, 24'h000000, 16'h0000, 2'b11, 1'b0);
        xfer(1'b0, 24'hFFFFFF, 16'h0000, 2'b11, 1'b0);
        // Highest in-range word.
        xfer(1'b1, 24'h0000FF, 16'hBEEF, 2'b11, 1'b0);
        xfer(1'b0, 24'h0000FF, 16'h0000, 2'b11, 1'b0);
        // Extra req pulse during WAIT is ignored; next req follows with no bubble.
        xfer(1'b1, 24'h000009, 16'h9999, 2'b11, 1'b1);
        xfer(1'b0, 24'h000009, 16'h0000, 2'b11, 1'b0);

        // Reset during WAIT of a write to addr 7 aborts it.
        xfer(1'b1, 24'h000007, 16'h7777, 2'b11, 1'b0);
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = 24'h000007;
        mem_o_data = 16'h0BAD;
        mem_sel    = 2'b11;
        @(posedge i_clk);
        #1;
        mem_req = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rstw_ack", ack0, 0);
        chk("rstw_exc", exc0, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rstw_ack_c2", ack0, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        xfer(1'b0, 24'h000007, 16'h0000, 2'b11, 1'b0);

        // Reset during the ack cycle of a read clears outputs without a clock edge.
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 24'h000007;
        @(posedge i_clk);
        #1;
        mem_req = 1'b0;
        @(posedge i_clk);
        #2;
        chk("pre_rst_ack", ack0, 1);
        chk("pre_rst_rd",  rd0,  16'h7777);
        i_rst_n = 1'b0;
        #1;
        chk("async_ack", ack0, 0);
        chk("async_rd",  rd0,  0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // LATENCY=1 instance: back-to-back transfers.
        tgt = 1'b1;
        xfer(1'b1, 24'h000005, 16'h2468, 2'b11, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b11, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b01, 1'b1);
        xfer(1'b1, 24'h000200, 16'h1111, 2'b11, 1'b0);
        xfer(1'b0, 24'h000005, 16'h0000, 2'b11, 1'b0);

        // Randomized mix across both instances.
        for (int n = 0; n < 400; n++) begin
            tgt = 1'($urandom);
            if ($urandom_range(0, 9) < 7)
                ra = 24'($urandom_range(0, 31));
            else
                ra = 24'($urandom_range(24'h000100, 24'hFFFFFF));
            xfer(1'($urandom), ra, 16'($urandom), 2'($urandom),
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
